// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for a shared packet bus between drvrs devices.
// Each packet takes a fixed four cycles: IDLE (arbitrate), POP (strobe and
// capture the head word), ROUTE (decode the destination byte), PUSH (deliver).
// Invalid destinations are dropped from ROUTE straight back to IDLE.
// All outputs come straight from registers.
module bus_rr_scheduler #(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic                       busy,
  output logic                       drop_err,
  output logic [15:0]                trans_cnt
);

  localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef logic [GW-1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_ROUTE = 2'd2,
    S_PUSH  = 2'd3
  } state_t;

  // One-hot decode of a device index, built bit by bit so that index codes
  // above drvrs-1 can never address a bit outside the vector.
  function automatic logic [drvrs-1:0] onehot(input idx_t i);
    logic [drvrs-1:0] m;
    for (int k = 0; k < drvrs; k++) begin
      m[k] = (idx_t'(k) == i);
    end
    return m;
  endfunction

  // First requester found searching upward from last+1 with wrap-around.
  // The caller only uses the result when at least one request is set.
  function automatic idx_t rr_pick(input logic [drvrs-1:0] req, input idx_t last);
    idx_t pick;
    logic found;
    int   cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      cand = int'(last) + k;
      if (cand >= drvrs) begin
        cand = cand - drvrs;
      end else begin
        cand = cand;
      end
      if (!found && req[idx_t'(cand)]) begin
        pick  = idx_t'(cand);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Saturating packet counter increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t               state_q, state_d;
  idx_t                 grant_q, grant_d;   // doubles as last_grant
  logic [pckg_sz-1:0]   pkt_q, pkt_d;
  logic [drvrs-1:0]     pop_q, pop_d;
  logic [drvrs-1:0]     push_q, push_d;
  logic [pckg_sz-1:0]   d_push_q, d_push_d;
  logic                 busy_q, busy_d;
  logic                 drop_q, drop_d;
  logic [15:0]          cnt_q, cnt_d;

  idx_t                 pick_s;
  logic [pckg_sz-1:0]   sel_s;
  logic [7:0]           dest_s;

  assign pick_s = rr_pick(pndng, grant_q);
  assign dest_s = pkt_q[pckg_sz-1 -: 8];

  // Head-of-FIFO word of the currently granted device.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (grant_q == idx_t'(i)) begin
        sel_s = D_pop[i*pckg_sz +: pckg_sz];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Next-state and registered-output values for the four-phase packet FSM.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    pkt_d    = pkt_q;
    pop_d    = '0;
    push_d   = '0;
    d_push_d = d_push_q;
    drop_d   = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|pndng) begin
          grant_d = pick_s;
          pop_d   = onehot(pick_s);
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        pkt_d   = sel_s;
        state_d = S_ROUTE;
      end
      S_ROUTE: begin
        if (dest_s == broadcast) begin
          push_d   = ~onehot(grant_q);
          d_push_d = pkt_q;
          cnt_d    = sat_inc(cnt_q);
          state_d  = S_PUSH;
        end else if (int'(dest_s) < drvrs) begin
          push_d   = onehot(idx_t'(dest_s));
          d_push_d = pkt_q;
          cnt_d    = sat_inc(cnt_q);
          state_d  = S_PUSH;
        end else begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any in-flight packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= idx_t'(drvrs - 1);
      pkt_q    <= '0;
      pop_q    <= '0;
      push_q   <= '0;
      d_push_q <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      pkt_q    <= pkt_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      d_push_q <= d_push_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pop       = pop_q;
  assign push      = push_q;
  assign D_push    = d_push_q;
  assign busy      = busy_q;
  assign drop_err  = drop_q;
  assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler (4 devices, 16-bit packets).
// Device FIFOs are modelled as queues; each observed pop pushes the expected
// delivery (mask, data, drop) onto a scoreboard, consumed two cycles later.
module tb_bus_rr_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] D_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] D_push;
  logic        busy;
  logic        drop_err;
  logic [15:0] trans_cnt;

  bus_rr_scheduler #(
    .drvrs(4),
    .pckg_sz(16),
    .broadcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pndng(pndng),
    .D_pop(D_pop),
    .pop(pop),
    .push(push),
    .D_push(D_push),
    .busy(busy),
    .drop_err(drop_err),
    .trans_cnt(trans_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  mask;
    logic [15:0] data;
    bit          drop;
  } sb_t;

  logic [15:0] dev_q [4][$];
  sb_t         sb [$];
  int          pop_log [$];
  int          pop_cyc [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pend_pop = -1;
  int          model_last = 3;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      pndng[i] = (dev_q[i].size() != 0);
      D_pop[i*16 +: 16] = (dev_q[i].size() != 0) ? dev_q[i][0] : 16'h0000;
    end
  endtask

  function automatic int rr(input logic [3:0] p, input int last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic sb_t expect_of(input int g, input logic [15:0] pkt, input int c);
    sb_t e;
    logic [7:0] d;
    d      = pkt[15:8];
    e.cyc  = c;
    e.data = pkt;
    e.drop = 1'b0;
    if (d == 8'hFF) begin
      e.mask = 4'hF & ~(4'b0001 << g);
    end else if (d < 8'd4) begin
      e.mask = 4'b0001 << d;
    end else begin
      e.mask = 4'b0000;
      e.drop = 1'b1;
    end
    return e;
  endfunction

  // One clock: update FIFO models, then check the settled DUT outputs.
  task automatic step();
    logic [3:0] sampled;
    int g;
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    sampled = pndng;
    if (pend_pop >= 0) begin
      if (dev_q[pend_pop].size() != 0) void'(dev_q[pend_pop].pop_front());
      pend_pop = -1;
      refresh();
    end
    if (reset) begin
      sb.delete();
      exp_cnt    = 16'd0;
      model_last = 3;
      chk("rst_pop", pop, 4'b0000);
      chk("rst_push", push, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      return;
    end
    chk("pop_onehot", ($countones(pop) <= 1), 1'b1);
    chk("pop_push_excl", ((pop != 4'b0000) && (push != 4'b0000)), 1'b0);
    if (pop != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (pop[i]) g = i;
      chk("grant", g, rr(sampled, model_last));
      chk("pop_pending", sampled[g], 1'b1);
      model_last = g;
      pop_log.push_back(g);
      pop_cyc.push_back(cyc);
      if (dev_q[g].size() != 0) sb.push_back(expect_of(g, dev_q[g][0], cyc + 2));
      pend_pop = g;
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("sb_push", push, e.mask);
      if (e.mask != 4'b0000) chk("sb_data", D_push, e.data);
      chk("sb_drop", drop_err, e.drop);
      if (!e.drop && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end else begin
      chk("stray_push", push, 4'b0000);
      chk("stray_drop", drop_err, 1'b0);
    end
    chk("trans_cnt", trans_cnt, exp_cnt);
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while ((sb.size() != 0 || pndng != 4'b0000 || busy || pend_pop >= 0) && n < budget) begin
      step();
      n++;
    end
    chk(tag, (n < budget), 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    pndng = 4'b0000;
    D_pop = 64'h0;
    #1;
    chk("reset_pop", pop, 4'b0000);
    chk("reset_push", push, 4'b0000);
    chk("reset_dpush", D_push, 16'h0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_drop", drop_err, 1'b0);
    chk("reset_cnt", trans_cnt, 16'h0000);
    step();
    step();
    reset = 1'b0;

    // Idle with nothing pending.
    repeat (3) step();
    chk("idle_busy", busy, 1'b0);

    // Round-robin: every device holds two packets for device 0.
    for (int i = 0; i < 4; i++) begin
      dev_q[i].push_back({8'h00, 8'(8'h10 + i)});
      dev_q[i].push_back({8'h00, 8'(8'h20 + i)});
    end
    refresh();
    pop_log.delete();
    pop_cyc.delete();
    run_until_idle(60, "rr_timeout");
    chk("rr_count", pop_log.size(), 8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("rr_order", pop_log[i], i % 4);
    for (int i = 1; i < pop_cyc.size(); i++) chk("rr_spacing", pop_cyc[i] - pop_cyc[i-1], 4);
    chk("rr_cnt", trans_cnt, 16'd8);

    // Single transfer from device 2 to device 1.
    dev_q[2].push_back(16'h01AB);
    refresh();
    step();
    chk("t2_pop", pop, 4'b0100);
    step();
    chk("t2_pop_clear", pop, 4'b0000);
    step();
    chk("t2_push", push, 4'b0010);
    chk("t2_data", D_push, 16'h01AB);
    chk("t2_busy", busy, 1'b1);
    chk("t2_cnt", trans_cnt, 16'd9);
    step();
    chk("t2_push_clear", push, 4'b0000);
    chk("t2_idle", busy, 1'b0);

    // Broadcast from device 1.
    dev_q[1].push_back(16'hFF55);
    refresh();
    step();
    chk("t4_pop", pop, 4'b0010);
    step();
    step();
    chk("t4_push", push, 4'b1101);
    chk("t4_data", D_push, 16'hFF55);
    chk("t4_cnt", trans_cnt, 16'd10);
    step();

    // Invalid destination from device 3.
    dev_q[3].push_back(16'h07AA);
    refresh();
    step();
    chk("t5_pop", pop, 4'b1000);
    step();
    chk("t5_busy_route", busy, 1'b1);
    step();
    chk("t5_drop", drop_err, 1'b1);
    chk("t5_push", push, 4'b0000);
    chk("t5_idle", busy, 1'b0);
    chk("t5_cnt", trans_cnt, 16'd10);
    step();
    chk("t5_drop_clear", drop_err, 1'b0);

    // Asynchronous reset during a PUSH cycle.
    dev_q[1].push_back(16'h02C3);
    refresh();
    step();
    step();
    step();
    chk("t1_push_before", push, 4'b0100);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_pop", pop, 4'b0000);
    chk("t1_push", push, 4'b0000);
    chk("t1_busy", busy, 1'b0);
    chk("t1_cnt", trans_cnt, 16'h0000);
    step();
    step();
    reset = 1'b0;
    repeat (2) step();

    // Reset during ROUTE loses the popped packet; last_grant restarts at 3.
    dev_q[2].push_back(16'h0133);
    refresh();
    step();
    chk("t6_pop", pop, 4'b0100);
    step();
    chk("t6_in_route", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_push", push, 4'b0000);
    chk("t6_busy", busy, 1'b0);
    step();
    step();
    reset = 1'b0;
    repeat (6) step();
    chk("t6_no_push_cnt", trans_cnt, 16'h0000);
    dev_q[0].push_back(16'h0211);
    dev_q[2].push_back(16'h0322);
    refresh();
    step();
    chk("t6_first_grant", pop, 4'b0001);
    run_until_idle(40, "t6_timeout");
    chk("t6_cnt", trans_cnt, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
